jogo_memoria_param: RTL
=======================

JOGO_MEMORIA_PARAM -- requirements
Module: jogo_memoria_param

Interface
REQ-001 The block SHALL have parameter N_BOTOES, default 4: number of buttons/LEDs (2..8).
REQ-002 The block SHALL have parameter PROFUNDIDADE, default 16: sequence memory depth (2..256). AW = clog2(PROFUNDIDADE).
REQ-003 The block SHALL have parameter TIMEOUT_CICLOS, default 5000: maximum wait per play, in clock cycles (>=2).
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-006 The block SHALL have port iniciar, input, 1 bit: start/restart request, level-sampled.
REQ-007 The block SHALL have port nivel, input, AW bits: final round index, sampled only when the game starts.
REQ-008 The block SHALL have port botoes, input, N_BOTOES bits: player buttons, synchronous to clock, one-hot expected.
REQ-009 The block SHALL have port acertou, output, 1 bit: game won.
REQ-010 The block SHALL have port errou, output, 1 bit: game lost by wrong play or timeout.
REQ-011 The block SHALL have port pronto, output, 1 bit: game finished.
REQ-012 The block SHALL have port leds, output, N_BOTOES bits: last registered play.
REQ-013 The block SHALL have port db_estado, output, 4 bits: state code.
REQ-014 The block SHALL have ports db_contagem and db_limite, output, AW bits each: current address and current round limit.
REQ-015 The block SHALL have ports db_tem_jogada, db_timeout and db_igual, output, 1 bit each: play pulse, timeout flag, and comparison result.

Function
REQ-016 The internal ROM SHALL hold, at address a, the one-hot value with bit (a mod N_BOTOES) set; for example, with defaults: 0001, 0010, 0100, 1000, 0001, ...
REQ-017 Play detection SHALL be a registered rising-edge detector on the OR of botoes; db_tem_jogada SHALL pulse for exactly 1 cycle per press, regardless of how long the button is held.
REQ-018 The FSM SHALL implement these states and codes: INICIAL=0, PREPARA=1, ESPERA=2, REGISTRA=3, COMPARA=4, PROXIMO=5, PROX_RODADA=6, FIM_ACERTO=A, FIM_ERRO=E, FIM_TIMEOUT=D.
REQ-019 INICIAL SHALL go to PREPARA when iniciar=1, and stay in INICIAL otherwise.
REQ-020 PREPARA SHALL clear the address counter, the limit counter and the play register, latch nivel (clamped to PROFUNDIDADE-1) as the final limit, and then go to ESPERA.
REQ-021 ESPERA SHALL increment the timeout counter every cycle (the counter is cleared on entry); on a play it SHALL go to REGISTRA, and when the counter reaches TIMEOUT_CICLOS-1 with no play it SHALL go to FIM_TIMEOUT.
REQ-022 When a play and the timeout occur in the same cycle, the play SHALL win.
REQ-023 REGISTRA SHALL load botoes into the play register (visible on leds the next cycle) and then go to COMPARA.
REQ-024 COMPARA SHALL go to FIM_ERRO if the play register differs from ROM[address]; multi-bit or all-zero plays therefore always count as errors.
REQ-025 On a match in COMPARA, the next state SHALL be:
  - FIM_ACERTO if address = limit = final limit;
  - PROX_RODADA if address = limit < final limit;
  - PROXIMO otherwise.
REQ-026 PROXIMO SHALL increment the address and go to ESPERA.
REQ-027 PROX_RODADA SHALL increment the limit, clear the address, and go to ESPERA.
REQ-028 In the FIM_* states, pronto SHALL be 1:
  - acertou=1 only in FIM_ACERTO;
  - errou=1 in FIM_ERRO and FIM_TIMEOUT;
  - db_timeout=1 only in FIM_TIMEOUT.
  All three states SHALL hold until iniciar=1, which leads to PREPARA.
REQ-029 Outputs SHALL be Moore, registered-state decoded, and SHALL NOT change combinationally with inputs, except db_igual, which is combinational.
REQ-030 Counters SHALL NOT wrap: the address never exceeds the limit, and the limit never exceeds the final limit.
REQ-031 iniciar SHALL be ignored in every non-final state other than INICIAL.

Reset
REQ-032 When reset=0 at a clock edge, the FSM SHALL go to INICIAL from any state, including mid-game, and all counters and the play register SHALL clear.
REQ-033 After reset, the outputs SHALL be: acertou=errou=pronto=0, leds=0, db_estado=0, db_contagem=db_limite=0, db_tem_jogada=db_timeout=0.
REQ-034 Reset SHALL take priority over iniciar and over botoes in the same cycle.

Verification (N_BOTOES=4, PROFUNDIDADE=16, TIMEOUT_CICLOS=20)
REQ-035 The bench SHALL cover a full win: nivel=2, then plays 0001 | 0001, 0010 | 0001, 0010, 0100 -> acertou=1, pronto=1, db_estado=A, db_limite=2.
REQ-036 The bench SHALL cover a wrong play: nivel=3, first play 0010 -> errou=1, db_estado=E, leds=0010, acertou=0.
REQ-037 The bench SHALL cover a timeout: start, then no press for 20 cycles -> db_estado=D, errou=1, db_timeout=1; a press on exactly the 20th cycle instead leads to REGISTRA.
REQ-038 The bench SHALL cover a held or multi-bit button: holding 0001 for 50 cycles -> a single db_tem_jogada pulse; pressing 0011 -> FIM_ERRO.
REQ-039 The bench SHALL cover reset mid-game: reset=0 while in ESPERA of round 2 -> the next cycle shows db_estado=0 and all outputs 0; then iniciar restarts at round 0.
REQ-040 The bench SHALL cover the nivel clamp: with PROFUNDIDADE=12 and nivel=15, the game ends with acertou after round 11 (db_limite=11).

Source files
------------

// File: rtl/jogo_memoria_param.sv
// Memory game: the player repeats a growing one-hot sequence read from an internal ROM,
// one extra step per round, until the latched final round is cleared, a play is wrong, or time runs out.
module jogo_memoria_param #(
  parameter  int N_BOTOES       = 4,
  parameter  int PROFUNDIDADE   = 16,
  parameter  int TIMEOUT_CICLOS = 5000,
  localparam int AW             = $clog2(PROFUNDIDADE)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                iniciar,
  input  logic [AW-1:0]       nivel,
  input  logic [N_BOTOES-1:0] botoes,
  output logic                acertou,
  output logic                errou,
  output logic                pronto,
  output logic [N_BOTOES-1:0] leds,
  output logic [3:0]          db_estado,
  output logic [AW-1:0]       db_contagem,
  output logic [AW-1:0]       db_limite,
  output logic                db_tem_jogada,
  output logic                db_timeout,
  output logic                db_igual
);

  localparam int TW = $clog2(TIMEOUT_CICLOS);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CICLOS - 1);
  localparam logic [AW-1:0] NIVEL_MAX = AW'(PROFUNDIDADE - 1);

  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARA     = 4'h1,
    ESPERA      = 4'h2,
    REGISTRA    = 4'h3,
    COMPARA     = 4'h4,
    PROXIMO     = 4'h5,
    PROX_RODADA = 4'h6,
    FIM_ACERTO  = 4'hA,
    FIM_TIMEOUT = 4'hD,
    FIM_ERRO    = 4'hE
  } estado_t;

  estado_t             state_q;
  logic [AW-1:0]       contagem_q;
  logic [AW-1:0]       limite_q;
  logic [AW-1:0]       limite_final_q;
  logic [N_BOTOES-1:0] jogada_q;
  logic [TW-1:0]       timer_q;
  logic                botao_ant_q;
  logic                tem_jogada_q;
  logic [N_BOTOES-1:0] rom_val;
  logic                igual;

  // ROM contents are implicit: address a holds the one-hot value with bit (a mod N_BOTOES) set.
  always_comb begin
    rom_val = '0;
    for (int i = 0; i < N_BOTOES; i++) begin
      rom_val[i] = ((int'(contagem_q) % N_BOTOES) == i);
    end
  end

  assign igual = (jogada_q == rom_val);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q        <= INICIAL;
      contagem_q     <= '0;
      limite_q       <= '0;
      limite_final_q <= '0;
      jogada_q       <= '0;
      timer_q        <= '0;
      botao_ant_q    <= 1'b0;
      tem_jogada_q   <= 1'b0;
    end else begin
      // One pulse per press: rising edge of "any button down", however long it is held.
      botao_ant_q  <= |botoes;
      tem_jogada_q <= (|botoes) & ~botao_ant_q;
      timer_q      <= '0;
      case (state_q)
        INICIAL: if (iniciar) state_q <= PREPARA;
        PREPARA: begin
          contagem_q     <= '0;
          limite_q       <= '0;
          jogada_q       <= '0;
          limite_final_q <= (nivel > NIVEL_MAX) ? NIVEL_MAX : nivel;
          state_q        <= ESPERA;
        end
        ESPERA: begin
          // A play arriving on the last allowed cycle still counts.
          if (tem_jogada_q)               state_q <= REGISTRA;
          else if (timer_q == TIMER_MAX)  state_q <= FIM_TIMEOUT;
          else                            timer_q <= timer_q + TW'(1);
        end
        REGISTRA: begin
          jogada_q <= botoes;
          state_q  <= COMPARA;
        end
        COMPARA: begin
          if (!igual)                          state_q <= FIM_ERRO;
          else if (contagem_q != limite_q)     state_q <= PROXIMO;
          else if (limite_q == limite_final_q) state_q <= FIM_ACERTO;
          else                                 state_q <= PROX_RODADA;
        end
        PROXIMO: begin
          contagem_q <= contagem_q + AW'(1);
          state_q    <= ESPERA;
        end
        PROX_RODADA: begin
          limite_q   <= limite_q + AW'(1);
          contagem_q <= '0;
          state_q    <= ESPERA;
        end
        FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: if (iniciar) state_q <= PREPARA;
        default: state_q <= INICIAL;
      endcase
    end
  end

  assign acertou       = (state_q == FIM_ACERTO);
  assign errou         = (state_q == FIM_ERRO) || (state_q == FIM_TIMEOUT);
  assign pronto        = acertou || errou;
  assign db_timeout    = (state_q == FIM_TIMEOUT);
  assign leds          = jogada_q;
  assign db_estado     = state_q;
  assign db_contagem   = contagem_q;
  assign db_limite     = limite_q;
  assign db_tem_jogada = tem_jogada_q;
  assign db_igual      = igual;

endmodule
